video_scanout: RTL and testbench

- Reader side of the 16x16 one-bit video RAM.
- Generates VGA raster timing (default 640x480 at 25 MHz pixel clock) and maps each active pixel to a RAM cell (x,y).
- Drives the RAM's shared x/y port for reads, then emits a pixel plus aligned hsync/vsync/de.
- Game-logic writes enter through a one-deep buffer and are forwarded to the RAM only during blanking, so reads and writes never collide on the shared address port.

---
 rtl/video_scanout.sv | 208 ++++++++++++++++++++
 tb/tb_video_scanout.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_scanout.sv
// video_scanout
//   Reader side of the 16x16 one-bit video RAM. Generates VGA raster timing,
//   maps each visible pixel onto a RAM cell, reads that cell through the
//   shared x/y port, and emits the pixel with aligned de/hsync/vsync two
//   cycles after the counter state. Host writes go into a one-deep buffer
//   and are forwarded to the RAM only during blanking.
//
// Ports
//   clk, rst_n          pixel clock, async active-low reset
//   wr_valid/wr_ready   host write handshake (ready = buffer empty)
//   wr_x, wr_y, wr_data host write cell coordinates and bit
//   mem_x, mem_y        shared RAM address (write address when mem_we)
//   mem_we, mem_wdata   RAM write strobe and data
//   mem_rdata           RAM read data, registered inside the RAM
//   pixel, de           pixel value and display enable
//   hsync, vsync        sync outputs, polarity set by SYNC_POL
//   frame_start         one-cycle pulse at raster origin, not delayed
module video_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CELL_W   = 32,
   parameter int CELL_H   = 30,
   parameter int SYNC_POL = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [3:0] wr_x,
   input  logic [3:0] wr_y,
   input  logic       wr_data,
   output logic [3:0] mem_x,
   output logic [3:0] mem_y,
   output logic       mem_we,
   output logic       mem_wdata,
   input  logic       mem_rdata,
   output logic       pixel,
   output logic       de,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW  = $clog2(H_TOTAL);
   localparam int VW  = $clog2(V_TOTAL);
   localparam int SXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int SYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

   localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0]  H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [VW-1:0]  V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [HW-1:0]  H_GRID_C = HW'(16 * CELL_W);
   localparam logic [VW-1:0]  V_GRID_C = VW'(16 * CELL_H);
   localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SXW-1:0] SX_LAST  = SXW'(CELL_W - 1);
   localparam logic [SYW-1:0] SY_LAST  = SYW'(CELL_H - 1);
   localparam logic           SYNC_LVL = (SYNC_POL != 0);

   logic [HW-1:0]  hcount_q, hcount_d;
   logic [VW-1:0]  vcount_q, vcount_d;
   logic [SXW-1:0] sub_x_q, sub_x_d;
   logic [SYW-1:0] sub_y_q, sub_y_d;
   logic [3:0]     cx_q, cx_d, cy_q, cy_d;
   logic           h_wrap, v_wrap;

   logic           act, in_grid, hs_raw, vs_raw;

   logic           pend_q, pend_d;
   logic [3:0]     wbx_q, wbx_d, wby_q, wby_d;
   logic           wbd_q, wbd_d;

   logic           act_d1_q, in_grid_d1_q, hs_d1_q, vs_d1_q;
   logic           pixel_q, pixel_d, de_q, hsync_q, hsync_d, vsync_q, vsync_d;

   // Raster and cell counters. Cell coordinates are tracked incrementally
   // alongside the raster so no division is needed; cx/cy saturate at 15
   // and the in_grid flag masks whatever lies beyond the grid.
   always_comb begin
      h_wrap   = (hcount_q == H_LAST);
      v_wrap   = (vcount_q == V_LAST);
      hcount_d = hcount_q + HW'(1);
      vcount_d = vcount_q;
      sub_x_d  = sub_x_q + SXW'(1);
      cx_d     = cx_q;
      sub_y_d  = sub_y_q;
      cy_d     = cy_q;
      if (sub_x_q == SX_LAST) begin
         sub_x_d = '0;
         if (cx_q != 4'hf) cx_d = cx_q + 4'd1;
      end
      if (h_wrap) begin
         hcount_d = '0;
         sub_x_d  = '0;
         cx_d     = '0;
         if (v_wrap) begin
            vcount_d = '0;
            sub_y_d  = '0;
            cy_d     = '0;
         end else begin
            vcount_d = vcount_q + VW'(1);
            if (sub_y_q == SY_LAST) begin
               sub_y_d = '0;
               if (cy_q != 4'hf) cy_d = cy_q + 4'd1;
            end else begin
               sub_y_d = sub_y_q + SYW'(1);
            end
         end
      end
   end

   always_comb begin
      act         = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
      in_grid     = (hcount_q < H_GRID_C) && (vcount_q < V_GRID_C);
      hs_raw      = (hcount_q >= HS_BEG) && (hcount_q < HS_END);
      vs_raw      = (vcount_q >= VS_BEG) && (vcount_q < VS_END);
      frame_start = (hcount_q == '0) && (vcount_q == '0);
   end

   // Write buffer: drains on the first blank cycle. Capture and drain can
   // never coincide because wr_ready is low for as long as pend is set.
   always_comb begin
      wr_ready  = !pend_q;
      mem_we    = pend_q && !act;
      mem_wdata = wbd_q;
      mem_x     = mem_we ? wbx_q : cx_q;
      mem_y     = mem_we ? wby_q : cy_q;
      pend_d    = pend_q;
      wbx_d     = wbx_q;
      wby_d     = wby_q;
      wbd_d     = wbd_q;
      if (mem_we) begin
         pend_d = 1'b0;
      end else if (wr_valid && !pend_q) begin
         pend_d = 1'b1;
         wbx_d  = wr_x;
         wby_d  = wr_y;
         wbd_d  = wr_data;
      end
   end

   // Stage 2. A read slot lost to a buffered write has act_d1 = 0, so its
   // data never reaches the pixel output.
   always_comb begin
      pixel_d = mem_rdata && act_d1_q && in_grid_d1_q;
      hsync_d = hs_d1_q ? SYNC_LVL : !SYNC_LVL;
      vsync_d = vs_d1_q ? SYNC_LVL : !SYNC_LVL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q     <= '0;
         vcount_q     <= '0;
         sub_x_q      <= '0;
         sub_y_q      <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         pend_q       <= 1'b0;
         wbx_q        <= '0;
         wby_q        <= '0;
         wbd_q        <= 1'b0;
         act_d1_q     <= 1'b0;
         in_grid_d1_q <= 1'b0;
         hs_d1_q      <= 1'b0;
         vs_d1_q      <= 1'b0;
         pixel_q      <= 1'b0;
         de_q         <= 1'b0;
         hsync_q      <= !SYNC_LVL;
         vsync_q      <= !SYNC_LVL;
      end else begin
         hcount_q     <= hcount_d;
         vcount_q     <= vcount_d;
         sub_x_q      <= sub_x_d;
         sub_y_q      <= sub_y_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         pend_q       <= pend_d;
         wbx_q        <= wbx_d;
         wby_q        <= wby_d;
         wbd_q        <= wbd_d;
         act_d1_q     <= act;
         in_grid_d1_q <= in_grid;
         hs_d1_q      <= hs_raw;
         vs_d1_q      <= vs_raw;
         pixel_q      <= pixel_d;
         de_q         <= act_d1_q;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
      end
   end

   assign pixel = pixel_q;
   assign de    = de_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;

endmodule

// File: tb/tb_video_scanout.sv
module tb_video_scanout;

   // Shrunk raster so several whole frames fit in a short run; the grid is
   // narrower and shorter than the active area so saturation and masking
   // are exercised.
   localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
   localparam int VA = 36, VFP = 2, VS = 2, VBP = 3;
   localparam int CW = 2, CH = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FR = HT * VT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic [3:0] wr_x = '0, wr_y = '0;
   logic       wr_data = 1'b0;
   logic       wr_ready;
   logic [3:0] mem_x, mem_y;
   logic       mem_we, mem_wdata;
   logic       mem_rdata = 1'b0;
   logic       pixel, de, hsync, vsync, frame_start;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   video_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .CELL_W(CW), .CELL_H(CH), .SYNC_POL(0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
      .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync),
      .frame_start(frame_start)
   );

   // Video RAM driven by the DUT: registered read, write on mem_we.
   logic ram [16][16];
   always @(posedge clk) begin
      if (mem_we) ram[mem_x][mem_y] <= mem_wdata;
      mem_rdata <= ram[mem_x][mem_y];
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s t=%0t got %h expected %h", name, $time, got, want);
         if (errors >= 40) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   endtask

   // ---------------- reference model ----------------
   // Raster position is derived from a plain cycle count since reset.
   function automatic int hpos(int n); return n % HT; endfunction
   function automatic int vpos(int n); return (n / HT) % VT; endfunction
   function automatic logic is_act(int n);
      return (hpos(n) < HA) && (vpos(n) < VA);
   endfunction
   function automatic logic is_grid(int n);
      return (hpos(n) < 16 * CW) && (vpos(n) < 16 * CH);
   endfunction
   function automatic logic is_hs(int n);
      return (hpos(n) >= HA + HFP) && (hpos(n) < HA + HFP + HS);
   endfunction
   function automatic logic is_vs(int n);
      return (vpos(n) >= VA + VFP) && (vpos(n) < VA + VFP + VS);
   endfunction
   function automatic logic [3:0] cell_x(int n);
      int c = hpos(n) / CW;
      return 4'((c > 15) ? 15 : c);
   endfunction
   function automatic logic [3:0] cell_y(int n);
      int c = vpos(n) / CH;
      return 4'((c > 15) ? 15 : c);
   endfunction

   logic       ref_ram [16][16];
   int         cyc = 0;
   logic       rp_pend = 1'b0;
   logic [3:0] rp_x = '0, rp_y = '0;
   logic       rp_d = 1'b0;
   logic       s1_act = 1'b0, s1_grid = 1'b0, s1_hs = 1'b0, s1_vs = 1'b0, s1_rd = 1'b0;
   logic       e_pix = 1'b0, e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc     <= 0;
         rp_pend <= 1'b0;
         s1_act  <= 1'b0; s1_grid <= 1'b0; s1_hs <= 1'b0; s1_vs <= 1'b0; s1_rd <= 1'b0;
         e_pix   <= 1'b0; e_de <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1;
      end else begin
         e_pix   <= s1_rd & s1_act & s1_grid;
         e_de    <= s1_act;
         e_hs    <= !s1_hs;
         e_vs    <= !s1_vs;
         s1_act  <= is_act(cyc);
         s1_grid <= is_grid(cyc);
         s1_hs   <= is_hs(cyc);
         s1_vs   <= is_vs(cyc);
         s1_rd   <= ref_ram[cell_x(cyc)][cell_y(cyc)];
         if (rp_pend && !is_act(cyc)) begin
            ref_ram[rp_x][rp_y] <= rp_d;
            rp_pend <= 1'b0;
         end else if (wr_valid && !rp_pend) begin
            rp_pend <= 1'b1;
            rp_x    <= wr_x;
            rp_y    <= wr_y;
            rp_d    <= wr_data;
         end
         cyc <= cyc + 1;
      end
   end

   // Every cycle out of reset: compare all outputs against the model.
   logic       m_we;
   logic [3:0] m_x, m_y;
   always @(negedge clk) begin
      if (rst_n) begin
         m_we = rp_pend && !is_act(cyc);
         m_x  = m_we ? rp_x : cell_x(cyc);
         m_y  = m_we ? rp_y : cell_y(cyc);
         check("raster_outputs",
               {17'd0, frame_start, de, hsync, vsync, pixel, wr_ready, mem_we,
                mem_we & mem_wdata, mem_x, mem_y},
               {17'd0, (cyc % FR) == 0, e_de, e_hs, e_vs, e_pix, !rp_pend, m_we,
                m_we & rp_d, m_x, m_y});
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_pos(int h, int v);
      int n = 0;
      while (!(hpos(cyc) == h && vpos(cyc) == v) && n < 3 * FR) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 3 * FR) begin
         checks++;
         errors++;
         $display("FAIL wait_pos timeout waiting for h=%0d v=%0d", h, v);
      end
   endtask

   task automatic do_reset(int n);
      @(posedge clk); #1;
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      #1;
      check("reset_state",
            {hsync, vsync, de, pixel, wr_ready, mem_we, frame_start, mem_x, mem_y},
            {7'b1100101, 8'h00});
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      int         h;
      int         v;
      logic [3:0] x;
      logic [3:0] y;
      logic       d;
      int         wait_c;
   } wr_vec_t;

   wr_vec_t tbl[8];
   int      n;

   initial begin
      // write issued at (h,v) -> cycles from capture edge until mem_we
      tbl[0] = '{10, 0,  4'd5,  4'd7,  1'b1, 30};  // mid active line
      tbl[1] = '{39, 5,  4'd0,  4'd0,  1'b1, 1};   // last active pixel
      tbl[2] = '{55, 3,  4'd15, 4'd15, 1'b1, 41};  // line end, next line active
      tbl[3] = '{20, 38, 4'd3,  4'd2,  1'b0, 1};   // vertical blank
      tbl[4] = '{55, 42, 4'd15, 4'd0,  1'b1, 41};  // frame end wraps to origin
      tbl[5] = '{0,  35, 4'd8,  4'd8,  1'b1, 40};  // start of last active line
      tbl[6] = '{55, 35, 4'd0,  4'd15, 1'b1, 1};   // into vertical blank
      tbl[7] = '{40, 10, 4'd3,  4'd2,  1'b1, 1};   // first h-blank pixel

      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++) begin
            ram[x][y]     = 1'b0;
            ref_ram[x][y] = 1'b0;
         end
      ram[3][2]     = 1'b1;
      ref_ram[3][2] = 1'b1;

      do_reset(3);
      repeat (FR + 10) begin @(posedge clk); #1; end

      for (int i = 0; i < 8; i++) begin
         wait_pos(tbl[i].h, tbl[i].v);
         wr_x = tbl[i].x; wr_y = tbl[i].y; wr_data = tbl[i].d;
         wr_valid = 1'b1;
         @(posedge clk); #1;
         wr_valid = 1'b0;
         check("wr_ready_drop", wr_ready, 0);
         n = 1;
         while (!mem_we && n < 200) begin @(posedge clk); #1; n++; end
         check("drain_wait", n, tbl[i].wait_c);
         check("drain_addr", {mem_x, mem_y, mem_wdata}, {tbl[i].x, tbl[i].y, tbl[i].d});
         @(posedge clk); #1;
         check("wr_ready_back", wr_ready, 1);
      end

      // back-to-back writes in vertical blanking
      wait_pos(0, 38);
      wr_x = 4'd9; wr_y = 4'd1; wr_data = 1'b1; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      check("b2b_first", {mem_we, wr_ready, mem_x, mem_y}, {2'b10, 4'd9, 4'd1});
      @(posedge clk); #1;
      check("b2b_ready", wr_ready, 1);
      wr_x = 4'd10; wr_y = 4'd1; wr_data = 1'b1; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      check("b2b_second", {mem_we, wr_ready, mem_x, mem_y}, {2'b10, 4'd10, 4'd1});

      // pending write dropped by a mid-line reset
      wait_pos(5, 3);
      wr_x = 4'd3; wr_y = 4'd2; wr_data = 1'b0; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      check("pend_held", {wr_ready, mem_we}, 2'b00);
      repeat (3) begin @(posedge clk); #1; end
      do_reset(2);
      check("ready_after_reset", wr_ready, 1);
      repeat (FR + 5) begin @(posedge clk); #1; end
      check("cell_kept", ram[3][2], 1);

      // random traffic, wr_valid asserted regardless of wr_ready
      repeat (2 * FR) begin
         @(posedge clk); #1;
         wr_valid = ($urandom_range(0, 7) == 0);
         wr_x     = 4'($urandom);
         wr_y     = 4'($urandom);
         wr_data  = 1'($urandom);
      end
      wr_valid = 1'b0;
      repeat (FR + 5) begin @(posedge clk); #1; end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
